// File: rtl/rv32i_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: data widths and the
// queued long-latency writeback request.
package rv32i_wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // A write to x0 is architecturally discarded.
  function automatic logic wr_visible(input logic [REG_AW-1:0] r);
    return r != '0;
  endfunction

endpackage

// File: rtl/rv32i_wb_arbiter_if.sv
// Bundle of writeback, long-latency result, hazard and register-port signals
// seen by the arbiter (slave) and by its surroundings (master).
interface rv32i_wb_arbiter_if;
  import rv32i_wb_pkg::*;

  logic              p_wb_en;
  logic [REG_AW-1:0] p_wb_reg;
  logic [XLEN-1:0]   p_wb_data;
  logic              p_stall;

  logic              s_valid;
  logic              s_ready;
  logic [REG_AW-1:0] s_reg;
  logic [XLEN-1:0]   s_data;
  logic              s_issue;
  logic [REG_AW-1:0] s_issue_reg;

  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic              raw_stall;

  logic              wb_en_out;
  logic [REG_AW-1:0] wb_reg_out;
  logic [XLEN-1:0]   wb_data;
  logic              df_wb_enable;
  logic [REG_AW-1:0] df_wb_reg;
  logic [XLEN-1:0]   df_wb_data;
  logic [NREGS-1:0]  busy_mask;

  modport slave (
    input  p_wb_en, p_wb_reg, p_wb_data,
    input  s_valid, s_reg, s_data, s_issue, s_issue_reg,
    input  rs1, rs2, rd,
    output p_stall, s_ready, raw_stall,
    output wb_en_out, wb_reg_out, wb_data,
    output df_wb_enable, df_wb_reg, df_wb_data, busy_mask
  );

  modport master (
    output p_wb_en, p_wb_reg, p_wb_data,
    output s_valid, s_reg, s_data, s_issue, s_issue_reg,
    output rs1, rs2, rd,
    input  p_stall, s_ready, raw_stall,
    input  wb_en_out, wb_reg_out, wb_data,
    input  df_wb_enable, df_wb_reg, df_wb_data, busy_mask
  );

endinterface

// File: rtl/rv32i_wb_arbiter_fifo.sv
// Show-ahead synchronous FIFO of long-latency writeback requests; the head is
// readable in the same cycle it becomes valid so the arbiter can grant it.
module rv32i_wb_fifo
  import rv32i_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_req_t     mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Single register-file write port shared between pipeline writeback and a
// queued long-latency unit, with anti-starvation, scoreboard and RAW stall.
module rv32i_wb_arbiter
  import rv32i_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  rv32i_wb_arbiter_if.slave   bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] GRANT_IDLE = 2'd0;
  localparam logic [1:0] GRANT_P    = 2'd1;
  localparam logic [1:0] GRANT_S    = 2'd2;

  logic [SW-1:0]     starve_q, starve_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_nonempty;
  wb_req_t    head;
  wb_req_t    s_req;
  logic       force_s;
  logic       grant_s;
  logic [1:0] grant_sel;

  assign s_req   = '{rd: bus.s_reg, data: bus.s_data};
  assign bus.s_ready = !fifo_full;

  rv32i_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (bus.s_valid && !fifo_full),
    .push_data (s_req),
    .pop       (grant_s),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_nonempty = !fifo_empty;
  assign force_s       = fifo_nonempty && (starve_q == STARVE_LIM);
  assign grant_s       = (grant_sel == GRANT_S);
  assign bus.p_stall   = force_s;

  // Starve counter only accumulates while P keeps winning over a waiting S.
  always_comb begin
    grant_sel = GRANT_IDLE;
    starve_d  = '0;
    if (force_s) begin
      grant_sel = GRANT_S;
    end else if (bus.p_wb_en) begin
      grant_sel = GRANT_P;
      if (fifo_nonempty) starve_d = starve_q + SW'(1);
    end else if (fifo_nonempty) begin
      grant_sel = GRANT_S;
    end
  end

  always_comb begin
    wb_en_d   = 1'b0;
    wb_reg_d  = '0;
    wb_data_d = '0;
    case (grant_sel)
      GRANT_S: begin
        wb_en_d   = wr_visible(head.rd);
        wb_reg_d  = head.rd;
        wb_data_d = head.data;
      end
      GRANT_P: begin
        wb_en_d   = wr_visible(bus.p_wb_reg);
        wb_reg_d  = bus.p_wb_reg;
        wb_data_d = bus.p_wb_data;
      end
      default: ;
    endcase
  end

  // Issue takes priority over a same-cycle retire so a reissued register stays busy.
  assign busy_d[0] = 1'b0;
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
    always_comb begin
      busy_d[gi] = busy_q[gi];
      if (grant_s && head.rd == REG_AW'(gi)) busy_d[gi] = 1'b0;
      if (bus.s_issue && bus.s_issue_reg == REG_AW'(gi)) busy_d[gi] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q  <= '0;
      busy_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.raw_stall    = busy_q[bus.rs1] | busy_q[bus.rs2] | busy_q[bus.rd];
  assign bus.busy_mask    = busy_q;
  assign bus.wb_en_out    = wb_en_q;
  assign bus.wb_reg_out   = wb_reg_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.df_wb_enable = wb_en_q;
  assign bus.df_wb_reg    = wb_reg_q;
  assign bus.df_wb_data   = wb_data_q;

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Directed bench for the writeback arbiter: pipeline path, long-latency path,
// starvation forcing, FIFO full back-pressure, x0 suppression and async reset.
module tb_rv32i_wb_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [37:0] got_w;
  logic [37:0] exp_w;

  rv32i_wb_arbiter_if bus ();

  rv32i_wb_arbiter #(
    .FIFO_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.p_wb_en = 1'b0; bus.p_wb_reg = '0; bus.p_wb_data = '0;
    bus.s_valid = 1'b0; bus.s_reg = '0; bus.s_data = '0;
    bus.s_issue = 1'b0; bus.s_issue_reg = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
  endtask

  task automatic check_out(input string name, input logic en, input logic [4:0] r,
                           input logic [31:0] d);
    got_w = {bus.wb_en_out, bus.wb_reg_out, bus.wb_data};
    exp_w = {en, r, d};
    checks++;
    if (got_w !== exp_w) begin
      errors++;
      $display("FAIL %s: got en=%0b reg=%0d data=%h want en=%0b reg=%0d data=%h",
               name, bus.wb_en_out, bus.wb_reg_out, bus.wb_data, en, r, d);
    end else
      $display("ok   %s: en=%0b reg=%0d data=%h", name, en, r, d);
  endtask

  task automatic test_reset();
    check_out("reset_out", 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.p_stall !== 1'b0 || bus.busy_mask !== 32'h0 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got p_stall=%0b busy=%h s_ready=%0b want 0/0/1",
               bus.p_stall, bus.busy_mask, bus.s_ready);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b want 1", bus.s_ready);
    end
  endtask

  task automatic test_p_only();
    bus.p_wb_en = 1'b1; bus.p_wb_reg = 5'd5; bus.p_wb_data = 32'hA5;
    #1;
    checks++;
    if (bus.p_stall !== 1'b0) begin
      errors++;
      $display("FAIL p_only_stall: got %0b want 0", bus.p_stall);
    end
    @(negedge clk);
    drive_idle(); #1;
    check_out("p_only_out", 1'b1, 5'd5, 32'hA5);
    got_w = {bus.df_wb_enable, bus.df_wb_reg, bus.df_wb_data};
    checks++;
    if (got_w !== {1'b1, 5'd5, 32'hA5}) begin
      errors++;
      $display("FAIL p_only_df: got %h want %h", got_w, {1'b1, 5'd5, 32'hA5});
    end
    @(negedge clk); #1;
    check_out("p_only_idle", 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_s_only();
    bus.s_issue = 1'b1; bus.s_issue_reg = 5'd7;
    @(negedge clk);
    bus.s_issue = 1'b0; bus.rs1 = 5'd7;
    bus.s_valid = 1'b1; bus.s_reg = 5'd7; bus.s_data = 32'h1234;
    #1;
    checks++;
    if (bus.busy_mask !== 32'h80 || bus.raw_stall !== 1'b1 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL s_busy_set: got busy=%h raw=%0b ready=%0b want 80/1/1",
               bus.busy_mask, bus.raw_stall, bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0; bus.rs1 = 5'd0; bus.rd = 5'd7;
    #1;
    checks++;
    if (bus.raw_stall !== 1'b1) begin
      errors++;
      $display("FAIL s_waw_stall: got %0b want 1", bus.raw_stall);
    end
    check_out("s_grant_cycle", 1'b0, 5'd0, 32'h0);
    @(negedge clk); #1;
    check_out("s_only_out", 1'b1, 5'd7, 32'h1234);
    checks++;
    if (bus.busy_mask !== 32'h0 || bus.raw_stall !== 1'b0) begin
      errors++;
      $display("FAIL s_busy_clear: got busy=%h raw=%0b want 0/0", bus.busy_mask, bus.raw_stall);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bus.p_wb_en = 1'b1; bus.p_wb_reg = 5'd10;
    for (int i = 0; i < 5; i++) begin
      bus.p_wb_data = 32'h100 + 32'(i);
      bus.s_valid = (i == 0); bus.s_reg = 5'd4; bus.s_data = 32'h44;
      #1;
      checks++;
      if (bus.p_stall !== 1'b0) begin
        errors++;
        $display("FAIL starve_no_stall_%0d: got %0b want 0", i, bus.p_stall);
      end
      if (i > 0) check_out($sformatf("starve_p_%0d", i - 1), 1'b1, 5'd10, 32'h100 + 32'(i - 1));
      @(negedge clk);
    end
    bus.s_valid = 1'b0; bus.p_wb_data = 32'h105;
    #1;
    checks++;
    if (bus.p_stall !== 1'b1) begin
      errors++;
      $display("FAIL starve_force: got p_stall=%0b want 1", bus.p_stall);
    end
    check_out("starve_p_4", 1'b1, 5'd10, 32'h104);
    @(negedge clk); #1;
    checks++;
    if (bus.p_stall !== 1'b0) begin
      errors++;
      $display("FAIL starve_release: got p_stall=%0b want 0", bus.p_stall);
    end
    check_out("starve_s_out", 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    drive_idle(); #1;
    check_out("starve_p_held", 1'b1, 5'd10, 32'h105);
    @(negedge clk);
  endtask

  task automatic test_full();
    bus.p_wb_en = 1'b1; bus.p_wb_reg = 5'd11; bus.p_wb_data = 32'h200;
    bus.s_valid = 1'b1; bus.s_reg = 5'd12; bus.s_data = 32'hA;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready0: got %0b want 1", bus.s_ready);
    end
    @(negedge clk);
    bus.s_reg = 5'd13; bus.s_data = 32'hB;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready1: got %0b want 1", bus.s_ready);
    end
    @(negedge clk);
    bus.s_reg = 5'd14; bus.s_data = 32'hC;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready2: got %0b want 0", bus.s_ready);
    end
    @(negedge clk);
    bus.p_wb_en = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_popping: got %0b want 0", bus.s_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_after_pop: got %0b want 1", bus.s_ready);
    end
    check_out("full_out_12", 1'b1, 5'd12, 32'hA);
    @(negedge clk);
    drive_idle(); #1;
    check_out("full_out_13", 1'b1, 5'd13, 32'hB);
    @(negedge clk); #1;
    check_out("full_out_14", 1'b1, 5'd14, 32'hC);
    @(negedge clk); #1;
    check_out("full_drained", 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_x0();
    bus.s_valid = 1'b1; bus.s_reg = 5'd0; bus.s_data = 32'hFFFF;
    bus.s_issue = 1'b1; bus.s_issue_reg = 5'd0;
    @(negedge clk);
    drive_idle(); #1;
    checks++;
    if (bus.busy_mask !== 32'h0) begin
      errors++;
      $display("FAIL x0_busy: got %h want 0", bus.busy_mask);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.wb_en_out !== 1'b0) begin
      errors++;
      $display("FAIL x0_s_suppress: got %0b want 0", bus.wb_en_out);
    end
    bus.p_wb_en = 1'b1; bus.p_wb_reg = 5'd0; bus.p_wb_data = 32'h55;
    @(negedge clk);
    drive_idle();
    bus.s_valid = 1'b1; bus.s_reg = 5'd6; bus.s_data = 32'h66;
    #1;
    checks++;
    if (bus.wb_en_out !== 1'b0) begin
      errors++;
      $display("FAIL x0_p_suppress: got %0b want 0", bus.wb_en_out);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk); #1;
    check_out("x0_fifo_drained", 1'b1, 5'd6, 32'h66);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.s_issue = 1'b1; bus.s_issue_reg = 5'd3;
    bus.p_wb_en = 1'b1; bus.p_wb_reg = 5'd20; bus.p_wb_data = 32'h300;
    bus.s_valid = 1'b1; bus.s_reg = 5'd3; bus.s_data = 32'h33;
    @(negedge clk);
    bus.s_issue = 1'b0; bus.s_reg = 5'd8; bus.s_data = 32'h88;
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy_mask !== 32'h8 || bus.s_ready !== 1'b0 || bus.wb_en_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got busy=%h ready=%0b en=%0b want 8/0/1",
               bus.busy_mask, bus.s_ready, bus.wb_en_out);
    end
    #1 reset = 1'b0;
    #1;
    check_out("rst_mid_out", 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.busy_mask !== 32'h0 || bus.s_ready !== 1'b1 || bus.p_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got busy=%h ready=%0b stall=%0b want 0/1/0",
               bus.busy_mask, bus.s_ready, bus.p_stall);
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk); #1;
    check_out("rst_mid_no_ghost", 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_p_only();
    test_s_only();
    test_starvation();
    test_full();
    test_x0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
